elevator_ctrl_n: RTL and testbench
==================================

Name: elevator_ctrl_n

Overview:
Parametrised successor to the 5-floor elevator FSM: one car serving NUM_FLOORS floors with latched car and hall calls, collective (SCAN) direction policy, a per-floor travel timer and a door-open dwell timer. It sits between the call-button inputs and the car motor/door/indicator drivers. Floor index is binary from 0; direction uses the existing 2-bit encoding.

Parameters:
NUM_FLOORS, 5, number of floors served (2..32)
MOVE_CYCLES, 4, clock cycles to travel one floor (>=1)
DOOR_CYCLES, 3, clock cycles door stays open per stop (>=1)

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
car_call  in  NUM_FLOORS  in-car floor buttons, 1-cycle pulse or level
hall_up  in  NUM_FLOORS  hall up buttons; bit NUM_FLOORS-1 ignored
hall_down  in  NUM_FLOORS  hall down buttons; bit 0 ignored
floor_idx  out  FW=max(1,$clog2(NUM_FLOORS))  current floor, registered
dir  out  2  00 idle, 10 up, 01 down, registered
door_open  out  1  high while in DOOR state
moving  out  1  high while in MOVE state
pending  out  NUM_FLOORS  OR of latched car/up/down calls per floor

Behaviour:
- Reset: state IDLE, floor_idx=0, dir=00, door_open=0, moving=0, all latched calls and pending=0, timers 0. Reset mid-move or with door open aborts immediately; car reported at floor 0.
- Latching: input bit high at edge t sets latched bit, visible on pending at t+1. Set wins over clear except on current floor in DOOR state (absorbed: clear wins).
- "Ahead" = any latched call on floors strictly beyond floor_idx in dir; "behind" likewise opposite.
- IDLE (dir=00): any call at floor_idx -> DOOR, clear all three calls at that floor. Else calls above -> MOVE, dir=10. Else calls below -> MOVE, dir=01. Above wins if both. Decision one cycle after pending shows call.
- MOVE: timer counts 0..MOVE_CYCLES-1; on terminal count floor_idx steps +/-1 and timer clears. Stop at new floor if car_call there, or hall call matching dir there, or nothing ahead (then any hall call there). Stop -> DOOR, clear car_call and matching-direction hall call; if nothing ahead, clear opposite hall call too. Otherwise stay in MOVE.
- floor_idx never leaves 0..NUM_FLOORS-1; MOVE never entered without a target in dir.
- DOOR: door_open=1 exactly DOOR_CYCLES cycles; dir held. At exit: ahead -> MOVE same dir; else behind -> MOVE reversed dir (opposite hall call at current floor, if pending, served first with another DOOR dwell); else IDLE, dir=00.
- moving/door_open mutually exclusive.

Optional Feature:
ELEVATOR_ESTOP_EN: adds input estop (1 bit). When high: no new calls latch; in MOVE finish current floor step then go to DOOR at that floor; DOOR holds (door_open=1) until estop low, then normal DOOR exit evaluation with a fresh DOOR_CYCLES dwell. IDLE with estop -> DOOR hold. Without macro: no estop port, behaviour as above.

Decomposition:
- Package elevator_pkg: DIR_IDLE=2'b00, DIR_UP=2'b10, DIR_DOWN=2'b01; state enum IDLE/MOVE/DOOR; function for FW.
- Sub-module elevator_call_reg: holds car/up/down call registers, set/clear logic, produces pending plus above/below/at-floor flags given floor_idx.

Test Plan (NUM_FLOORS=5, MOVE_CYCLES=4, DOOR_CYCLES=3):
- Reset held 2 cycles -> floor_idx=0, dir=00, door_open=0, moving=0, pending=5'b00000.
- Idle floor 0, car_call=5'b10000 one cycle -> pending=10000 next cycle, dir=10 cycle after, floor_idx 1,2,3,4 every 4 cycles, door_open 3 cycles at 4, then dir=00, pending=0.
- Idle floor 2, hall_down[2] pulse -> DOOR 3 cycles, no movement, bit cleared, back to IDLE.
- Idle floor 2, car_call[0] and car_call[4] same cycle -> moves up first, stops 4, reverses dir=01, stops 0.
- Moving up from 1 with car_call[4], hall_down[3] and hall_up[2] latched -> stops 2 (up call), passes 3, stops 4, reverses, stops 3.
- Reset asserted while moving between floors 2->3 -> next cycle floor_idx=0, moving=0, pending=0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared encodings and width helpers for the elevator controller.
package elevator_pkg;
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DOWN = 2'b01;

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, DOOR = 2'd2} state_e;

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/elevator_call_reg.sv
// Latched car/hall call registers with per-floor set/clear and direction
// summary flags evaluated at a query floor.
module elevator_call_reg
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 5,
  parameter int FW         = idx_w(NUM_FLOORS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] set_car,
  input  logic [NUM_FLOORS-1:0] set_up,
  input  logic [NUM_FLOORS-1:0] set_dn,
  input  logic [FW-1:0]         qry_floor,
  input  logic                  clr_car,
  input  logic                  clr_up,
  input  logic                  clr_dn,
  input  logic                  clr_wins,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  above,
  output logic                  below,
  output logic                  at_car,
  output logic                  at_up,
  output logic                  at_dn
);
  logic [NUM_FLOORS-1:0] car_q, car_d, up_q, up_d, dn_q, dn_d;
  logic [NUM_FLOORS-1:0] hit, gt, lt;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
    assign hit[i] = (qry_floor == FW'(i));
    assign gt[i]  = (FW'(i) > qry_floor);
    assign lt[i]  = (FW'(i) < qry_floor);
  end

  // With the door open at this floor a fresh press is absorbed, so clear wins.
  function automatic logic [NUM_FLOORS-1:0] upd(input logic [NUM_FLOORS-1:0] q,
                                                input logic [NUM_FLOORS-1:0] s,
                                                input logic [NUM_FLOORS-1:0] k,
                                                input logic w);
    return w ? ((q | s) & ~k) : ((q & ~k) | s);
  endfunction

  always_comb begin
    car_d = upd(car_q, set_car, hit & {NUM_FLOORS{clr_car}}, clr_wins);
    up_d  = upd(up_q,  set_up,  hit & {NUM_FLOORS{clr_up}},  clr_wins);
    dn_d  = upd(dn_q,  set_dn,  hit & {NUM_FLOORS{clr_dn}},  clr_wins);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      car_q <= '0;
      up_q  <= '0;
      dn_q  <= '0;
    end else begin
      car_q <= car_d;
      up_q  <= up_d;
      dn_q  <= dn_d;
    end
  end

  assign pending = car_q | up_q | dn_q;
  assign above   = |(pending & gt);
  assign below   = |(pending & lt);
  assign at_car  = |(car_q & hit);
  assign at_up   = |(up_q & hit);
  assign at_dn   = |(dn_q & hit);
endmodule

// File: rtl/elevator_ctrl_n.sv
// Single-car SCAN elevator controller with travel and door dwell timers.
// Optional emergency stop input enabled by defining ELEVATOR_ESTOP_EN.
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int  NUM_FLOORS  = 5,
  parameter int  MOVE_CYCLES = 4,
  parameter int  DOOR_CYCLES = 3,
  localparam int FW          = idx_w(NUM_FLOORS)
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                  estop,
`endif
  input  logic [NUM_FLOORS-1:0] car_call,
  input  logic [NUM_FLOORS-1:0] hall_up,
  input  logic [NUM_FLOORS-1:0] hall_down,
  output logic [FW-1:0]         floor_idx,
  output logic [1:0]            dir,
  output logic                  door_open,
  output logic                  moving,
  output logic [NUM_FLOORS-1:0] pending
);
  localparam int TW = idx_w(MOVE_CYCLES > DOOR_CYCLES ? MOVE_CYCLES : DOOR_CYCLES);
  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  state_e          state_q, state_d;
  logic [FW-1:0]   floor_q, floor_d, step_floor, qry_floor;
  logic [1:0]      dir_q, dir_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            estop_w, step;
  logic            clr_car, clr_up, clr_dn;
  logic            above, below, at_car, at_up, at_dn;
  logic            ahead, behind, at_match, at_opp;
  logic [NUM_FLOORS-1:0] set_mask;

`ifdef ELEVATOR_ESTOP_EN
  assign estop_w = estop;
`else
  assign estop_w = 1'b0;
`endif

  assign set_mask = {NUM_FLOORS{~estop_w}};

  // On the final travel cycle the flags are looked up at the floor being entered.
  assign step       = (state_q == MOVE) && (timer_q == MOVE_LAST);
  assign step_floor = (dir_q == DIR_UP) ? floor_q + FW'(1) : floor_q - FW'(1);
  assign qry_floor  = step ? step_floor : floor_q;

  elevator_call_reg #(.NUM_FLOORS(NUM_FLOORS), .FW(FW)) u_calls (
    .clock     (clock),
    .reset     (reset),
    .set_car   (car_call & set_mask),
    .set_up    (hall_up & UP_MASK & set_mask),
    .set_dn    (hall_down & DN_MASK & set_mask),
    .qry_floor (qry_floor),
    .clr_car   (clr_car),
    .clr_up    (clr_up),
    .clr_dn    (clr_dn),
    .clr_wins  (state_q == DOOR),
    .pending   (pending),
    .above     (above),
    .below     (below),
    .at_car    (at_car),
    .at_up     (at_up),
    .at_dn     (at_dn)
  );

  always_comb begin
    ahead    = 1'b0;
    behind   = 1'b0;
    at_match = 1'b0;
    at_opp   = 1'b0;
    if (dir_q == DIR_UP) begin
      ahead = above; behind = below; at_match = at_up; at_opp = at_dn;
    end else if (dir_q == DIR_DOWN) begin
      ahead = below; behind = above; at_match = at_dn; at_opp = at_up;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      floor_q <= '0;
      dir_q   <= DIR_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    clr_car = 1'b0;
    clr_up  = 1'b0;
    clr_dn  = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (estop_w || at_car || at_up || at_dn) begin
          state_d = DOOR;
          clr_car = 1'b1; clr_up = 1'b1; clr_dn = 1'b1;
        end else if (above) begin
          state_d = MOVE; dir_d = DIR_UP;
        end else if (below) begin
          state_d = MOVE; dir_d = DIR_DOWN;
        end
      end
      MOVE: begin
        if (step) begin
          floor_d = step_floor;
          timer_d = '0;
          // Nothing further ahead: this is the turnaround, serve both hall calls.
          if (estop_w || at_car || at_match || !ahead) begin
            state_d = DOOR;
            clr_car = 1'b1;
            clr_up  = (dir_q == DIR_UP) || !ahead;
            clr_dn  = (dir_q == DIR_DOWN) || !ahead;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DOOR: begin
        clr_car = 1'b1;
        clr_up  = (dir_q != DIR_DOWN);
        clr_dn  = (dir_q != DIR_UP);
        if (estop_w) begin
          timer_d = '0;
        end else if (timer_q == DOOR_LAST) begin
          timer_d = '0;
          if (ahead) begin
            state_d = MOVE;
          end else if (behind) begin
            dir_d = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
            // A waiting hall call for the new direction gets its own dwell here.
            if (at_opp) begin
              clr_up = 1'b1; clr_dn = 1'b1;
            end else begin
              state_d = MOVE;
            end
          end else begin
            state_d = IDLE;
            dir_d   = DIR_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    floor_idx = floor_q;
    dir       = dir_q;
    door_open = (state_q == DOOR);
    moving    = (state_q == MOVE);
  end
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Scenario bench for elevator_ctrl_n (5 floors, 4-cycle travel, 3-cycle dwell).
module tb_elevator_ctrl_n;
  localparam int N = 5;
  localparam logic [1:0] D_IDLE = 2'b00, D_UP = 2'b10, D_DN = 2'b01;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] car_call = '0, hall_up = '0, hall_down = '0;
`ifdef ELEVATOR_ESTOP_EN
  logic estop = 1'b0;
`endif
  logic [2:0]   floor_idx;
  logic [1:0]   dir;
  logic         door_open, moving;
  logic [N-1:0] pending;

  int checks = 0;
  int failures = 0;

  typedef struct packed {logic [2:0] fl; logic [1:0] d;} stop_t;
  stop_t exp_q[$];
  stop_t obs_q[$];

  always #5 clock = ~clock;

  elevator_ctrl_n #(.NUM_FLOORS(5), .MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef ELEVATOR_ESTOP_EN
    .estop     (estop),
`endif
    .car_call  (car_call),
    .hall_up   (hall_up),
    .hall_down (hall_down),
    .floor_idx (floor_idx),
    .dir       (dir),
    .door_open (door_open),
    .moving    (moving),
    .pending   (pending)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  // Runs until the car is idle with no calls, logging every door opening.
  task automatic run_collect(input int max_cyc, output bit to);
    bit prev;
    int n;
    prev = door_open;
    n = 0;
    do begin
      tick();
      n++;
      if (door_open && !prev) obs_q.push_back('{fl: floor_idx, d: dir});
      prev = door_open;
    end while (!(!moving && !door_open && pending == '0 && dir == D_IDLE) && n < max_cyc);
    to = !(!moving && !door_open && pending == '0 && dir == D_IDLE);
  endtask

  task automatic go_to(input int f);
    bit to;
    car_call = '0;
    car_call[f] = 1'b1;
    tick();
    car_call = '0;
    run_collect(200, to);
    obs_q.delete();
    checks++;
    if (to || floor_idx !== 3'(f)) begin
      failures++;
      $display("FAIL go_to_%0d floor=%0d timeout=%0d", f, floor_idx, to);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    checks++;
    if ({floor_idx, dir, door_open, moving, pending} !== 12'b0) begin
      failures++;
      $display("FAIL reset_state floor=%0d dir=%b door=%b moving=%b pending=%b exp all zero",
               floor_idx, dir, door_open, moving, pending);
    end
    reset = 1'b0;
  endtask

  task automatic test_run_to_top();
    car_call = 5'b10000;
    tick();
    car_call = '0;
    checks++;
    if (pending !== 5'b10000 || dir !== D_IDLE) begin
      failures++;
      $display("FAIL top_latch pending=%b dir=%b exp 10000/00", pending, dir);
    end
    tick();
    checks++;
    if (dir !== D_UP || moving !== 1'b1 || floor_idx !== 3'd0) begin
      failures++;
      $display("FAIL top_start dir=%b moving=%b floor=%0d exp 10/1/0", dir, moving, floor_idx);
    end
    for (int f = 1; f <= 4; f++) begin
      tick(4);
      checks++;
      if (floor_idx !== 3'(f) || moving !== (f != 4) || door_open !== (f == 4)) begin
        failures++;
        $display("FAIL top_step floor=%0d moving=%b door=%b exp floor %0d", floor_idx, moving,
                 door_open, f);
      end
    end
    tick(2);
    checks++;
    if (door_open !== 1'b1) begin
      failures++;
      $display("FAIL top_dwell door=%b exp 1", door_open);
    end
    tick();
    checks++;
    if (door_open !== 1'b0 || dir !== D_IDLE || pending !== '0 || floor_idx !== 3'd4) begin
      failures++;
      $display("FAIL top_done door=%b dir=%b pending=%b floor=%0d exp 0/00/0/4", door_open, dir,
               pending, floor_idx);
    end
  endtask

  task automatic test_hall_here();
    go_to(2);
    hall_down = 5'b00100;
    tick();
    hall_down = '0;
    checks++;
    if (pending !== 5'b00100 || door_open !== 1'b0) begin
      failures++;
      $display("FAIL here_latch pending=%b door=%b exp 00100/0", pending, door_open);
    end
    tick();
    checks++;
    if (door_open !== 1'b1 || moving !== 1'b0 || pending !== '0) begin
      failures++;
      $display("FAIL here_open door=%b moving=%b pending=%b exp 1/0/0", door_open, moving, pending);
    end
    car_call = 5'b00100;
    tick();
    car_call = '0;
    checks++;
    if (pending !== '0 || door_open !== 1'b1) begin
      failures++;
      $display("FAIL here_absorb pending=%b door=%b exp 00000/1", pending, door_open);
    end
    tick();
    checks++;
    if (door_open !== 1'b1) begin
      failures++;
      $display("FAIL here_dwell door=%b exp 1", door_open);
    end
    tick();
    checks++;
    if (door_open !== 1'b0 || moving !== 1'b0 || dir !== D_IDLE || floor_idx !== 3'd2) begin
      failures++;
      $display("FAIL here_done door=%b moving=%b dir=%b floor=%0d exp 0/0/00/2", door_open,
               moving, dir, floor_idx);
    end
  endtask

  task automatic test_both_ends();
    bit to;
    stop_t e, o;
    car_call = 5'b10001;
    exp_q.push_back('{fl: 3'd4, d: D_UP});
    exp_q.push_back('{fl: 3'd0, d: D_DN});
    tick();
    car_call = '0;
    run_collect(300, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL ends_timeout floor=%0d pending=%b", floor_idx, pending);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL ends_missing_stop exp floor=%0d dir=%b", e.fl, e.d);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL ends_stop got floor=%0d dir=%b exp floor=%0d dir=%b", o.fl, o.d, e.fl, e.d);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL ends_extra_stops count=%0d exp 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_collective();
    bit to;
    stop_t e, o;
    go_to(1);
    car_call  = 5'b10000;
    hall_down = 5'b01000;
    hall_up   = 5'b00100;
    exp_q.push_back('{fl: 3'd2, d: D_UP});
    exp_q.push_back('{fl: 3'd4, d: D_UP});
    exp_q.push_back('{fl: 3'd3, d: D_DN});
    tick();
    car_call = '0; hall_down = '0; hall_up = '0;
    checks++;
    if (pending !== 5'b11100) begin
      failures++;
      $display("FAIL coll_latch pending=%b exp 11100", pending);
    end
    run_collect(400, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL coll_timeout floor=%0d pending=%b", floor_idx, pending);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL coll_missing_stop exp floor=%0d dir=%b", e.fl, e.d);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL coll_stop got floor=%0d dir=%b exp floor=%0d dir=%b", o.fl, o.d, e.fl, e.d);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL coll_extra_stops count=%0d exp 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_ignored_bits();
    hall_up   = 5'b10000;
    hall_down = 5'b00001;
    tick();
    hall_up = '0; hall_down = '0;
    checks++;
    if (pending !== '0) begin
      failures++;
      $display("FAIL ignored_bits pending=%b exp 00000", pending);
    end
    tick();
    checks++;
    if (moving !== 1'b0 || door_open !== 1'b0 || dir !== D_IDLE) begin
      failures++;
      $display("FAIL ignored_idle moving=%b door=%b dir=%b exp 0/0/00", moving, door_open, dir);
    end
  endtask

  task automatic test_reset_mid_move();
    go_to(2);
    car_call = 5'b10000;
    tick();
    car_call = '0;
    tick(3);
    checks++;
    if (moving !== 1'b1 || floor_idx !== 3'd2 || dir !== D_UP) begin
      failures++;
      $display("FAIL mid_setup moving=%b floor=%0d dir=%b exp 1/2/10", moving, floor_idx, dir);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (floor_idx !== 3'd0 || moving !== 1'b0 || pending !== '0 || dir !== D_IDLE ||
        door_open !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset floor=%0d moving=%b pending=%b dir=%b door=%b exp all zero",
               floor_idx, moving, pending, dir, door_open);
    end
    tick(2);
    checks++;
    if (moving !== 1'b0 || door_open !== 1'b0 || floor_idx !== 3'd0) begin
      failures++;
      $display("FAIL mid_stays_idle moving=%b door=%b floor=%0d exp 0/0/0", moving, door_open,
               floor_idx);
    end
  endtask

  initial begin
    test_reset();
    test_run_to_top();
    test_hall_here();
    test_both_ends();
    test_collective();
    test_ignored_bits();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
